// File: rtl/aes_pkg.sv
// Shared AES-128 constants and byte helpers for the mode engine and its round datapath.
// No logic of its own; every function is a constant lookup or a small XOR network.
// No flow control here; handshakes live in the engine.
package aes_pkg;

    localparam int NR_AES128 = 10;

    localparam logic [2:0] MODE_ECB_ENC = 3'd0;
    localparam logic [2:0] MODE_CBC_ENC = 3'd1;
    localparam logic [2:0] MODE_CFB_ENC = 3'd2;
    localparam logic [2:0] MODE_CFB_DEC = 3'd3;
    localparam logic [2:0] MODE_OFB     = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } eng_state_e;

    localparam logic [0:255][7:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // State bytes are column-major with byte 0 in the MSBs of the 128-bit word.
    function automatic int unsigned bidx(input int unsigned row, input int unsigned col);
        return 4 * col + row;
    endfunction

    function automatic logic [7:0] get_byte(input logic [127:0] s, input int unsigned idx);
        return s[127 - 8 * idx -: 8];
    endfunction

endpackage

// File: rtl/aes_round_fwd.sv
// One forward AES round with on-the-fly next-round-key derivation.
// Purely combinational, zero cycles.
// No flow control; the enclosing engine decides when the result is registered.
module aes_round_fwd
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] rk,
    input  logic [7:0]   rcon,
    input  logic         last,
    output logic [127:0] next_state,
    output logic [127:0] next_rk
);

    logic [31:0]  t_word;
    logic [31:0]  w0, w1, w2, w3;
    logic [7:0]   sr [16];
    logic [7:0]   mc [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] body;

    always_comb begin
        t_word = {sbox(rk[23:16]), sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])} ^ {rcon, 24'h0};
        w0 = rk[127:96] ^ t_word;
        w1 = rk[95:64]  ^ w0;
        w2 = rk[63:32]  ^ w1;
        w3 = rk[31:0]   ^ w2;
        next_rk = {w0, w1, w2, w3};
    end

    always_comb begin
        a0 = 8'h00;
        a1 = 8'h00;
        a2 = 8'h00;
        a3 = 8'h00;
        body = '0;
        // SubBytes and ShiftRows together: row r rotates left by r columns.
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                sr[bidx(r, c)] = sbox(get_byte(state, bidx(r, (c + r) % 4)));
            end
        end
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = sr[bidx(0, c)];
            a1 = sr[bidx(1, c)];
            a2 = sr[bidx(2, c)];
            a3 = sr[bidx(3, c)];
            mc[bidx(0, c)] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            mc[bidx(1, c)] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            mc[bidx(2, c)] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            mc[bidx(3, c)] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        for (int unsigned i = 0; i < 16; i++) begin
            body[127 - 8 * i -: 8] = last ? sr[i] : mc[i];
        end
        next_state = body ^ next_rk;
    end

endmodule

// File: rtl/aes128_mode_engine.sv
// Iterative AES-128 encryptor with ECB/CBC/CFB-enc/CFB-dec/OFB chaining and a held IV register.
// Latency NR/RPC cycles from accept to out_valid; one block per NR/RPC+2 cycles at best.
// Accepts only in IDLE; out_ready=0 parks the result in HOLD indefinitely without loss.
module aes128_mode_engine
    import aes_pkg::*;
#(
    parameter int RPC = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [2:0]   mode,
    input  logic [127:0] key,
    input  logic [127:0] iv,
    input  logic         iv_load,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
);

    localparam int NR = NR_AES128;

    if (!(RPC == 1 || RPC == 2 || RPC == 5 || RPC == 10)) begin : g_rpc_illegal
        $error("aes128_mode_engine: RPC must be 1, 2, 5 or 10");
    end

    eng_state_e   state_q, state_d;
    logic [127:0] blk_q, rk_q, din_q, chain_q;
    logic [3:0]   rnd_q;
    logic [2:0]   mode_q;

    logic [2:0]   mode_in;
    logic [127:0] chain_in, cin, e_blk, rk_nxt, res, chain_nxt;
    logic         accept, last_cyc;

    for (genvar k = 0; k < RPC; k++) begin : g_round
        logic [127:0] st_in, rk_in, st_out, rk_out;
        logic [3:0]   ridx;
        if (k == 0) begin : g_first
            assign st_in = blk_q;
            assign rk_in = rk_q;
        end else begin : g_next
            assign st_in = g_round[k-1].st_out;
            assign rk_in = g_round[k-1].rk_out;
        end
        // ridx counts completed rounds, so this instance performs round ridx+1.
        assign ridx = rnd_q + 4'(k);
        aes_round_fwd u_round (
            .state      (st_in),
            .rk         (rk_in),
            .rcon       (rcon(ridx)),
            .last       (ridx == 4'(NR - 1)),
            .next_state (st_out),
            .next_rk    (rk_out)
        );
    end

    assign e_blk    = g_round[RPC-1].st_out;
    assign rk_nxt   = g_round[RPC-1].rk_out;
    assign last_cyc = (rnd_q == 4'(NR - RPC));
    assign accept   = in_valid && in_ready;
    assign busy     = !in_ready;

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN:     if (last_cyc) state_d = HOLD;
            HOLD:    if (out_valid && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // A same-cycle iv_load feeds the accepted block directly.
    always_comb begin
        mode_in  = (mode > MODE_OFB) ? MODE_ECB_ENC : mode;
        chain_in = iv_load ? iv : chain_q;
        case (mode_in)
            MODE_ECB_ENC: cin = data_in;
            MODE_CBC_ENC: cin = data_in ^ chain_in;
            default:      cin = chain_in;
        endcase
    end

    always_comb begin
        res       = e_blk;
        chain_nxt = chain_q;
        case (mode_q)
            MODE_CBC_ENC: chain_nxt = e_blk;
            MODE_CFB_ENC: begin
                res       = e_blk ^ din_q;
                chain_nxt = e_blk ^ din_q;
            end
            MODE_CFB_DEC: begin
                res       = e_blk ^ din_q;
                chain_nxt = din_q;
            end
            MODE_OFB: begin
                res       = e_blk ^ din_q;
                chain_nxt = e_blk;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            chain_q   <= '0;
            rnd_q     <= '0;
            blk_q     <= '0;
            rk_q      <= '0;
            din_q     <= '0;
            mode_q    <= MODE_ECB_ENC;
        end else begin
            case (state_q)
                IDLE: begin
                    if (iv_load) chain_q <= iv;
                    if (accept) begin
                        blk_q  <= cin ^ key;
                        rk_q   <= key;
                        rnd_q  <= '0;
                        mode_q <= mode_in;
                        din_q  <= data_in;
                    end
                end
                RUN: begin
                    blk_q <= e_blk;
                    rk_q  <= rk_nxt;
                    rnd_q <= rnd_q + 4'(RPC);
                    if (last_cyc) begin
                        out_valid <= 1'b1;
                        data_out  <= res;
                        chain_q   <= chain_nxt;
                    end
                end
                HOLD: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/aes128_mode_engine.md
Name: aes128_mode_engine

Overview:
- Iterative AES-128 forward-cipher engine with per-block selectable chaining mode: ECB-enc, CBC-enc, CFB128-enc, CFB128-dec, OFB.
- Holds the IV/chaining register across blocks and uses valid/ready handshakes on input and output.
- Parametrised unroll gives 1, 2, 5 or 10 rounds per clock.
- Sits between the image-block streamer and the output packer; it succeeds the single-mode ECB encryptor.

Parameters:
- RPC, 1, AES rounds executed per clock; legal values 1, 2, 5, 10; anything else is an elaboration error.
- NR, 10, total rounds. Fixed for AES-128 and kept as a localparam-style constant.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- mode  in  3  0=ECB_ENC, 1=CBC_ENC, 2=CFB_ENC, 3=CFB_DEC, 4=OFB; 5-7 treated as ECB_ENC
- key  in  128  cipher key; sampled on input accept
- iv  in  128  initialisation vector
- iv_load  in  1  load iv into the chaining register
- in_valid  in  1  data_in valid
- in_ready  out  1  engine can accept a block
- data_in  in  128  plaintext, or ciphertext for CFB_DEC
- out_valid  out  1  data_out valid
- out_ready  in  1  downstream accepts data_out
- data_out  out  128  result block
- busy  out  1  state is not IDLE

Behaviour:
- FSM states: IDLE, RUN, HOLD. in_ready = (state==IDLE). busy = !in_ready.
- Reset (rst_n=0 at a clk edge, from any state, including mid-RUN or HOLD):
  - state=IDLE, out_valid=0, data_out=0, chain=0, round counter=0.
  - The in-flight block is discarded.
- iv_load:
  - Honoured only in IDLE: chain <= iv.
  - Ignored in RUN and HOLD.
  - If iv_load and an accept occur in the same cycle, the accepted block uses iv as its chaining value (bypass).
- Accept (in_valid && in_ready):
  - Latch mode, key, data_in.
  - Cipher input cin: ECB_ENC = data_in; CBC_ENC = data_in^chain; CFB_* and OFB = chain.
  - state_reg <= cin^key, rk <= key, rnd <= 0, go to RUN.
- RUN:
  - Each cycle applies RPC rounds via aes_round_fwd instances in series.
  - Each instance derives the next round key on the fly using Rcon[rnd+k].
  - Round NR omits MixColumns.
  - After NR/RPC cycles in RUN, E = final state; go to HOLD with out_valid=1.
  - Latency: the block accepted at edge T gives out_valid=1 after edge T+NR/RPC (10 cycles for RPC=1, 1 cycle for RPC=10).
- Result and chain update, applied on the RUN→HOLD edge:
  - ECB_ENC: out=E; chain unchanged.
  - CBC_ENC: out=E; chain<=E.
  - CFB_ENC: out=E^P; chain<=E^P.
  - CFB_DEC: out=E^C; chain<=C, where C = latched data_in.
  - OFB: out=E^P; chain<=E.
- HOLD:
  - data_out and out_valid stay stable until out_ready=1.
  - On out_valid && out_ready: out_valid<=0, go to IDLE.
  - No same-cycle re-accept, so the maximum rate is one block per NR/RPC+2 cycles.
- Inputs are ignored while not IDLE. key, mode and data_in may change freely after accept.
- A mode change between blocks is legal; chain is preserved, so the user must reload the IV.
- Throughput/back-pressure: an arbitrarily long out_ready=0 stalls the engine in HOLD with no data loss.

Decomposition:
- Package aes_pkg holds:
  - the mode encodings (localparams MODE_ECB_ENC … MODE_OFB);
  - the S-box as a 256-entry constant function sbox(byte);
  - xtime();
  - the Rcon table rcon(idx), idx 0..9 → 01,02,04,08,10,20,40,80,1b,36;
  - the column-major state byte-order helper.
- Sub-module aes_round_fwd, purely combinational:
  - inputs: state, rk, rcon, last;
  - outputs: next_state = (last ? SR(SB(s)) : MC(SR(SB(s)))) ^ next_rk, and next_rk.
- The top generates RPC instances of aes_round_fwd.

Test Plan:
- FIPS-197 C.1, mode=0, key=000102030405060708090a0b0c0d0e0f, data_in=00112233445566778899aabbccddeeff → data_out=69c4e0d86a7b0430d8cdb78070b4c55a. Check the latency is exactly NR/RPC cycles for every legal RPC.
- SP800-38A common setup for the next three scenarios: key=2b7e151628aed2a6abf7158809cf4f3c, iv_load with iv=000102030405060708090a0b0c0d0e0f, P1=6bc1bee22e409f96e93d7e117393172a, P2=ae2d8a571e03ac9c9eb76fac45af8e51.
- CBC_ENC → 7649abac8119b246cee98e9b12e9197d, then 5086cb9b507219ee95db113a917678b2. ECB on P1 gives 3ad77bb40d7a3660a89ecaf32466ef97.
- CFB_ENC → 3b3fd92eb72dad20333449f8e83cfb4a, then c8a64537a0b3a93fcde3cdad9f1ce58b. Reload the IV, run CFB_DEC on those two ciphertexts → P1, P2. OFB block2 → 7789508d16918f03f53c52dac54ed825.
- Back-pressure: hold out_ready=0 for 20 cycles → out_valid stays 1, data_out stable, in_ready=0, in_valid pulses ignored. Release → one transfer, then in_ready=1.
- Reset and iv_load edge cases:
  - Drive rst_n=0 at round 5 → the next cycle is IDLE with out_valid=0 and chain=0.
  - Pulse iv_load during RUN → ignored.
  - iv_load together with accept in CBC → the new IV is used.
